// File: rtl/ais_phase_pkg.sv
// Shared phase constants and types for the phase differentiator/integrator pair.
// K_PI is 3 plus 0.1416015625 (145/1024) truncated to the fractional width.
package ais_phase_pkg;

   localparam int PHASE_W     = 16;
   localparam int PHASE_INT_W = 9;

   typedef logic signed [PHASE_W-1:0] phase_t;

   function automatic int k_pi_calc(input int w, input int int_w);
      int frac;
      int f;
      frac = w - int_w;
      if (frac >= 10) f = 145 << (frac - 10);
      else            f = 145 >> (10 - frac);
      return (3 << frac) + f;
   endfunction

   function automatic int k_2pi_calc(input int w, input int int_w);
      return k_pi_calc(w, int_w) << 1;
   endfunction

endpackage

// File: rtl/phase_wrap_add.sv
// Clamp a phase difference to [-K_PI, K_PI], add it to the accumulator
// at one extra bit, and fold the result back into range with one correction.
module phase_wrap_add
   import ais_phase_pkg::*;
#(
   parameter int PAR_PHASE_WIDTH     = 16,
   parameter int PAR_PHASE_INT_WIDTH = 9
) (
   input  logic signed [PAR_PHASE_WIDTH-1:0] acc,
   input  logic signed [PAR_PHASE_WIDTH-1:0] diff,
   output logic signed [PAR_PHASE_WIDTH-1:0] sum,
   output logic                              wrapped,
   output logic                              clipped
);

   localparam int W = PAR_PHASE_WIDTH;
   localparam logic signed [W:0] KPI =
      (W+1)'(k_pi_calc(PAR_PHASE_WIDTH, PAR_PHASE_INT_WIDTH));
   localparam logic signed [W:0] K2PI =
      (W+1)'(k_2pi_calc(PAR_PHASE_WIDTH, PAR_PHASE_INT_WIDTH));
   localparam logic signed [W:0] NKPI = -KPI;

   logic signed [W:0] d_x;
   logic signed [W:0] d_c;
   logic signed [W:0] acc_x;
   logic signed [W:0] s_raw;
   logic signed [W:0] s;

   always_comb begin
      d_x     = {diff[W-1], diff};
      acc_x   = {acc[W-1], acc};
      d_c     = d_x;
      clipped = 1'b0;
      if (d_x > KPI) begin
         d_c     = KPI;
         clipped = 1'b1;
      end else if (d_x < NKPI) begin
         d_c     = NKPI;
         clipped = 1'b1;
      end
      s_raw   = acc_x + d_c;
      s       = s_raw;
      wrapped = 1'b0;
      if (s_raw > KPI) begin
         s       = s_raw - K2PI;
         wrapped = 1'b1;
      end else if (s_raw < NKPI) begin
         s       = s_raw + K2PI;
         wrapped = 1'b1;
      end
      sum = s[W-1:0];
   end

endmodule

// File: rtl/phase_integrator.sv
// Frame-aware phase integrator: wrapped diffs in, absolute phase out (AXI-S).
// Define PHASE_INTEG_WRAP_CNT_EN to add the o_wrap_cnt wrap counter port.
module phase_integrator
   import ais_phase_pkg::*;
#(
   parameter int PAR_PHASE_WIDTH     = 16,
   parameter int PAR_PHASE_INT_WIDTH = 9,
   parameter int PAR_WCNT_WIDTH      = 8
) (
   input  logic                              i_clk,
   input  logic                              i_rst_n,
   input  logic                              i_init_vld,
   input  logic signed [PAR_PHASE_WIDTH-1:0] i_init_phase,
   input  logic                              s_axis_tvalid,
   output logic                              s_axis_tready,
   input  logic signed [PAR_PHASE_WIDTH-1:0] s_axis_tdata,
   input  logic                              s_axis_tlast,
   output logic                              m_axis_tvalid,
   input  logic                              m_axis_tready,
   output logic signed [PAR_PHASE_WIDTH-1:0] m_axis_tdata,
   output logic                              m_axis_tlast,
`ifdef PHASE_INTEG_WRAP_CNT_EN
   output logic [PAR_WCNT_WIDTH-1:0]         o_wrap_cnt,
`endif
   output logic                              o_clip
);

   localparam int W = PAR_PHASE_WIDTH;

   logic signed [W-1:0] acc;
   logic signed [W-1:0] acc_eff;
   logic signed [W-1:0] sum;
   logic                wrapped;
   logic                clipped;
   logic                accept;

   assign s_axis_tready = ~m_axis_tvalid | m_axis_tready;
   assign accept        = s_axis_tvalid & s_axis_tready;
   assign acc_eff       = i_init_vld ? i_init_phase : acc;

   phase_wrap_add #(
      .PAR_PHASE_WIDTH     (PAR_PHASE_WIDTH),
      .PAR_PHASE_INT_WIDTH (PAR_PHASE_INT_WIDTH)
   ) u_add (
      .acc     (acc_eff),
      .diff    (s_axis_tdata),
      .sum     (sum),
      .wrapped (wrapped),
      .clipped (clipped)
   );

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         acc           <= '0;
         m_axis_tvalid <= 1'b0;
         m_axis_tdata  <= '0;
         m_axis_tlast  <= 1'b0;
         o_clip        <= 1'b0;
      end else begin
         if (accept) begin
            m_axis_tdata  <= sum;
            m_axis_tvalid <= 1'b1;
            m_axis_tlast  <= s_axis_tlast;
            // a frame end restarts the next frame from zero phase
            acc           <= s_axis_tlast ? '0 : sum;
         end else begin
            if (m_axis_tready) m_axis_tvalid <= 1'b0;
            if (i_init_vld)    acc           <= i_init_phase;
         end
         if (accept && clipped) o_clip <= 1'b1;
         else if (i_init_vld)   o_clip <= 1'b0;
      end
   end

`ifdef PHASE_INTEG_WRAP_CNT_EN
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         o_wrap_cnt <= '0;
      end else if (accept && s_axis_tlast) begin
         o_wrap_cnt <= '0;
      end else if (i_init_vld) begin
         o_wrap_cnt <= PAR_WCNT_WIDTH'(accept & wrapped);
      end else if (accept && wrapped && !(&o_wrap_cnt)) begin
         o_wrap_cnt <= o_wrap_cnt + 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_phase_integrator.sv
// Directed bench for phase_integrator: vector table plus stall/reset sequences.
module tb_phase_integrator;
   import ais_phase_pkg::*;

   logic   clk = 1'b0;
   logic   rst_n;
   logic   init_vld;
   phase_t init_phase;
   logic   s_tvalid;
   logic   s_tready;
   phase_t s_tdata;
   logic   s_tlast;
   logic   m_tvalid;
   logic   m_tready;
   phase_t m_tdata;
   logic   m_tlast;
   logic   clip;
`ifdef PHASE_INTEG_WRAP_CNT_EN
   logic [7:0] wcnt;
`endif

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   phase_integrator dut (
      .i_clk         (clk),
      .i_rst_n       (rst_n),
      .i_init_vld    (init_vld),
      .i_init_phase  (init_phase),
      .s_axis_tvalid (s_tvalid),
      .s_axis_tready (s_tready),
      .s_axis_tdata  (s_tdata),
      .s_axis_tlast  (s_tlast),
      .m_axis_tvalid (m_tvalid),
      .m_axis_tready (m_tready),
      .m_axis_tdata  (m_tdata),
      .m_axis_tlast  (m_tlast),
`ifdef PHASE_INTEG_WRAP_CNT_EN
      .o_wrap_cnt    (wcnt),
`endif
      .o_clip        (clip)
   );

   typedef struct {
      logic init;
      int   init_ph;
      int   d;
      logic last;
      int   exp;
      logic exp_last;
      logic exp_clip;
   } vec_t;

   vec_t tab[$];

   task automatic add(input logic init, input int ph, input int d,
                      input logic last, input int exp,
                      input logic el, input logic ec);
      vec_t v;
      v = '{init, ph, d, last, exp, el, ec};
      tab.push_back(v);
   endtask

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s act=%0d exp=%0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n      = 1'b0;
      init_vld   = 1'b0;
      init_phase = '0;
      s_tvalid   = 1'b0;
      s_tdata    = '0;
      s_tlast    = 1'b0;
      m_tready   = 1'b1;

      // test 1
      add(0, 0, 100, 0, 100, 0, 0);
      add(0, 0, 100, 0, 200, 0, 0);
      add(0, 0, 100, 0, 300, 0, 0);
      add(0, 0, 100, 0, 400, 0, 0);
      add(0, 0, 100, 0, -304, 0, 0);
      // test 2
      add(1, 0, -402, 0, -402, 0, 0);
      add(0, 0, -402, 0, 0, 0, 0);
      add(0, 0, -402, 0, -402, 0, 0);
      // test 4
      add(1, 0, 50, 0, 50, 0, 0);
      add(0, 0, 50, 0, 100, 0, 0);
      add(0, 0, 50, 1, 150, 1, 0);
      add(0, 0, 50, 0, 50, 0, 0);
      // test 5
      add(1, 390, 20, 0, -394, 0, 0);
      add(0, 0, 1000, 0, 8, 0, 1);
      add(0, 0, -1000, 0, -394, 0, 1);
      add(1, 0, -402, 0, -402, 0, 0);

      repeat (2) @(posedge clk);
      #1;
      chk("rst_tvalid", int'(m_tvalid), 0);
      chk("rst_tdata", int'(m_tdata), 0);
      chk("rst_tlast", int'(m_tlast), 0);
      chk("rst_clip", int'(clip), 0);
      chk("rst_s_tready", int'(s_tready), 1);
      @(negedge clk);
      rst_n = 1'b1;

      foreach (tab[i]) begin
         @(negedge clk);
         init_vld   = tab[i].init;
         init_phase = phase_t'(tab[i].init_ph);
         s_tvalid   = 1'b1;
         s_tdata    = phase_t'(tab[i].d);
         s_tlast    = tab[i].last;
         tick();
         chk($sformatf("v%0d_valid", i), int'(m_tvalid), 1);
         chk($sformatf("v%0d_data", i), int'(m_tdata), tab[i].exp);
         chk($sformatf("v%0d_last", i), int'(m_tlast),
             int'(tab[i].exp_last));
         chk($sformatf("v%0d_clip", i), int'(clip), int'(tab[i].exp_clip));
`ifdef PHASE_INTEG_WRAP_CNT_EN
         if (i == 4) chk("wcnt_t1", int'(wcnt), 1);
`endif
      end

      // test 3: stall with an init pulse that must only touch acc
      @(negedge clk);
      init_vld   = 1'b1;
      init_phase = '0;
      s_tvalid   = 1'b1;
      s_tdata    = 16'sd10;
      s_tlast    = 1'b0;
      tick();
      chk("st_first", int'(m_tdata), 10);
      @(negedge clk);
      init_vld = 1'b0;
      m_tready = 1'b0;
      #1;
      chk("st_s_tready_lo", int'(s_tready), 0);
      tick();
      chk("st_hold1", int'(m_tdata), 10);
      @(negedge clk);
      init_vld   = 1'b1;
      init_phase = 16'sd100;
      tick();
      chk("st_hold2", int'(m_tdata), 10);
      chk("st_hold2_v", int'(m_tvalid), 1);
      @(negedge clk);
      init_vld = 1'b0;
      tick();
      chk("st_hold3", int'(m_tdata), 10);
      @(negedge clk);
      m_tready = 1'b1;
      #1;
      chk("st_s_tready_hi", int'(s_tready), 1);
      tick();
      chk("st_resume1", int'(m_tdata), 110);
      tick();
      chk("st_resume2", int'(m_tdata), 120);
      @(negedge clk);
      s_tvalid = 1'b0;
      tick();
      chk("st_drain", int'(m_tvalid), 0);

      // test 6: reset mid-stream while stalled
      @(negedge clk);
      s_tvalid = 1'b1;
      s_tdata  = 16'sd1000;
      s_tlast  = 1'b1;
      m_tready = 1'b0;
      tick();
      chk("r6_data", int'(m_tdata), -282);
      chk("r6_last", int'(m_tlast), 1);
      chk("r6_clip", int'(clip), 1);
      @(negedge clk);
      s_tvalid = 1'b0;
      s_tlast  = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      chk("r6_rst_valid", int'(m_tvalid), 0);
      chk("r6_rst_data", int'(m_tdata), 0);
      chk("r6_rst_last", int'(m_tlast), 0);
      chk("r6_rst_clip", int'(clip), 0);
      @(negedge clk);
      rst_n    = 1'b1;
      m_tready = 1'b1;
      @(negedge clk);
      s_tvalid = 1'b1;
      s_tdata  = 16'sd7;
      tick();
      chk("r6_after", int'(m_tdata), 7);
      chk("r6_after_v", int'(m_tvalid), 1);
      @(negedge clk);
      s_tvalid = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
